// File: rtl/inst_loader_pkg.sv
// Shared types and parameters for the boot-time instruction loader.
// Optional feature macro: INST_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
package inst_loader_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;

  localparam addr_t       InstStartFrom = 32'h0000_1000;
  localparam int unsigned InstSpace     = 32'd1024;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    WORD,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Little-endian 4-byte assembler: byte k of a word lands in bits [8k+7:8k].
// next_word presents the word including the byte currently offered, so the
// caller can act on a complete word in the same cycle the last byte arrives.
module inst_loader_byte_assembler
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output inst_t       next_word,
  output logic [2:0]  count,
  output logic        full
);

  inst_t word;

  assign full = count[2];

  // Merge the offered byte into the slot selected by the byte counter
  always_comb begin
    next_word = word;
    if (!full) begin
      next_word[count[1:0]*8 +: 8] = byte_in;
    end
  end

  // Capture accepted bytes; clear has priority over shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (shift_en && !full) begin
      word  <= next_word;
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader: takes a byte stream (16-bit word count, then
// little-endian 32-bit words) and writes each word into the fetcher.
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over all word bytes, checked in the CHECK state.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter addr_t       BASE_ADDR = InstStartFrom,
  parameter int unsigned MAX_WORDS = InstSpace >> 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        load,
  output inst_t       load_inst,
  output addr_t       addr,
  output logic        chip_select,
  output logic        busy,
  output logic        done,
  output logic        error
);

  loader_state_t state;
  logic [15:0]   n_words;
  logic [15:0]   idx;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic          accept;
  logic          len_last;
  logic          word_last;
  logic          asm_clear;
  logic          asm_shift;
  logic          asm_full;
  logic [2:0]    asm_count;
  inst_t         asm_next;
  logic [15:0]   len_value;

  // Handshake and byte-position decode for the current state
  always_comb begin
    accept    = byte_ready & byte_valid;
    asm_shift = accept & ((state == LEN) | (state == WORD));
    len_last  = (state == LEN)  & accept & (asm_count == 3'd1);
    word_last = (state == WORD) & accept & (asm_count == 3'd3);
    len_value = asm_next[15:0];
    // Empty the assembler outside sessions, after the length, and while a
    // completed word is being written out
    asm_clear = (state == IDLE) | (state == DONE) | (state == ERROR) |
                asm_full | len_last;
  end

  inst_loader_byte_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (byte_in),
    .next_word (asm_next),
    .count     (asm_count),
    .full      (asm_full)
  );

  // Session FSM with registered outputs; load/addr/load_inst are set on the
  // edge that accepts the 4th byte so the write pulse lands in WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_words     <= '0;
      idx         <= '0;
      byte_ready  <= 1'b0;
      load        <= 1'b0;
      load_inst   <= '0;
      addr        <= '0;
      chip_select <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state       <= LEN;
            idx         <= '0;
            byte_ready  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            chip_select <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
          end
        end

        LEN: begin
          if (len_last) begin
            n_words <= len_value;
            if (len_value == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
              state       <= CHECK;
`else
              state       <= DONE;
              byte_ready  <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              chip_select <= 1'b1;
`endif
            end else if (32'(len_value) > MAX_WORDS) begin
              state      <= ERROR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end else begin
              state <= WORD;
            end
          end
        end

        WORD: begin
`ifdef INST_LOADER_CHECKSUM_EN
          if (accept) begin
            csum <= csum ^ byte_in;
          end
`endif
          if (word_last) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            load       <= 1'b1;
            load_inst  <= asm_next;
            addr       <= BASE_ADDR + addr_t'({idx, 2'b00});
          end
        end

        WRITE: begin
          load <= 1'b0;
          idx  <= idx + 16'd1;
          if (idx + 16'd1 == n_words) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state       <= CHECK;
            byte_ready  <= 1'b1;
`else
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            chip_select <= 1'b1;
`endif
          end else begin
            state      <= WORD;
            byte_ready <= 1'b1;
          end
        end

`ifdef INST_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_in == csum) begin
              state       <= DONE;
              done        <= 1'b1;
              chip_select <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          load       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: randomized byte streams checked
// against a list-of-writes reference model and a small fetcher memory.
// Build with +define+INST_LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam addr_t       BASE = InstStartFrom;
  localparam int unsigned MAXW = InstSpace >> 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       load;
  inst_t      load_inst;
  addr_t      addr;
  logic       chip_select;
  logic       busy;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  inst_loader #(
    .BASE_ADDR (InstStartFrom),
    .MAX_WORDS (InstSpace >> 2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .load        (load),
    .load_inst   (load_inst),
    .addr        (addr),
    .chip_select (chip_select),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    load_cnt = 0;
  addr_t exp_addr_q[$];
  inst_t exp_inst_q[$];
  inst_t words[$];
  inst_t fmem[addr_t];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Fetcher side: every write pulse must match the next expected write
  always @(negedge clk) begin
    if (rst_n && load) begin
      load_cnt++;
      fmem[addr] = load_inst;
      if (exp_addr_q.size() == 0) begin
        check_eq("unexpected_load", 32'(load), 32'd0);
      end else begin
        check_eq("load_addr", addr, exp_addr_q.pop_front());
        check_eq("load_inst", load_inst, exp_inst_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit stray);
    int gap;
    int t;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    byte_valid = 1'b0;
    repeat (gap) begin
      start = stray && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      check_eq("byte_accept_timeout", 32'(byte_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || error) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("session_end", 32'(done | error), 32'd1);
  endtask

  // Model: a legal count yields writes BASE+4*i of words[i]; success iff the
  // count fits (and, with the checksum, the trailing byte is the XOR)
  task automatic run_session(input int n, input int max_gap, input bit stray, input bit bad_csum);
    bit         legal;
    bit         exp_ok;
    logic [7:0] x;
    inst_t      w;
    legal  = (n <= int'(MAXW));
    exp_ok = legal;
`ifdef INST_LOADER_CHECKSUM_EN
    exp_ok = legal && !bad_csum;
`endif
    x = 8'h00;
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        exp_addr_q.push_back(BASE + 32'(4 * i));
        exp_inst_q.push_back(words[i]);
        for (int k = 0; k < 4; k++) x ^= 8'(words[i] >> (8 * k));
      end
    end
    start_session();
    send_byte(8'(n), max_gap, stray);
    send_byte(8'(n >> 8), max_gap, stray);
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), max_gap, stray);
      end
`ifdef INST_LOADER_CHECKSUM_EN
      send_byte(x ^ {7'd0, bad_csum}, max_gap, stray);
`endif
    end
    wait_end();
    check_eq("sess_done", 32'(done), 32'(exp_ok));
    check_eq("sess_error", 32'(error), 32'(!exp_ok));
    check_eq("sess_cs", 32'(chip_select), 32'(exp_ok));
    check_eq("sess_busy", 32'(busy), 32'd0);
    check_eq("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom());
  endtask

  initial begin
    inst_t saved[$];
    int    lc;

    // Reset state
    #3;
    check_eq("reset_flags", {26'd0, load, chip_select, busy, done, error, byte_ready}, 32'd0);
    check_eq("reset_addr", addr, 32'd0);
    check_eq("reset_inst", load_inst, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 32'(byte_ready), 32'd0);

    // Directed two-word load
    words.delete();
    words.push_back(32'h2008_0005);
    words.push_back(32'h0000_0000);
    run_session(2, 0, 1'b0, 1'b0);
    check_eq("fetch_read", fmem[BASE], 32'h2008_0005);

    // Empty program
    lc = load_cnt;
    start_session();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    check_eq("n0_check_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 0, 1'b0);
`endif
    check_eq("n0_done", 32'(done), 32'd1);
    check_eq("n0_cs", 32'(chip_select), 32'd1);
    check_eq("n0_no_load", 32'(load_cnt), 32'(lc));

    // Oversized count, then restart clears error
    lc = load_cnt;
    words.delete();
    run_session(int'(MAXW) + 1, 0, 1'b0, 1'b0);
    check_eq("over_no_load", 32'(load_cnt), 32'(lc));
    start_session();
    check_eq("restart_error", 32'(error), 32'd0);
    check_eq("restart_busy", 32'(busy), 32'd1);
    check_eq("restart_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0, 1'b0);
`endif
    wait_end();
    check_eq("restart_done", 32'(done), 32'd1);

    // Same random programs without and with gaps plus stray starts
    for (int r = 0; r < 4; r++) begin
      fill_random($urandom_range(1, 8));
      saved = words;
      run_session(words.size(), 0, 1'b0, 1'b0);
      words = saved;
      run_session(words.size(), 3, 1'b1, 1'b0);
    end

    // Full capacity: last write lands at BASE+4*(MAXW-1)
    fill_random(int'(MAXW));
    run_session(int'(MAXW), 0, 1'b0, 1'b0);
    check_eq("cap_last_word", fmem[BASE + 32'(4 * (MAXW - 1))], words[MAXW - 1]);

    // Reset after the 2nd word of N=4
    fill_random(4);
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(BASE + 32'(4 * i));
      exp_inst_q.push_back(words[i]);
    end
    start_session();
    send_byte(8'd4, 0, 1'b0);
    send_byte(8'd0, 0, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) send_byte(8'(words[i] >> (8 * k)), 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_flags", {26'd0, load, chip_select, busy, done, error, byte_ready}, 32'd0);
    check_eq("midrst_addr", addr, 32'd0);
    check_eq("midrst_inst", load_inst, 32'd0);
    check_eq("midrst_two_written", 32'(exp_addr_q.size()), 32'd2);
    exp_addr_q.delete();
    exp_inst_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random(3);
    run_session(3, 2, 1'b0, 1'b0);

`ifdef INST_LOADER_CHECKSUM_EN
    // Checksum over bytes 01 02 03 04 is 04
    words.delete();
    words.push_back(32'h0403_0201);
    run_session(1, 0, 1'b0, 1'b0);
    words.delete();
    words.push_back(32'h0403_0201);
    run_session(1, 0, 1'b0, 1'b1);
    fill_random(5);
    run_session(5, 2, 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
